// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper command queue.
//   state_t         : sequencer FSM states
//   STEP_DIR_BIT    : direction bit inside the sign-magnitude step word
//   WATCHDOG_CYCLES : START cycles allowed before the driver is declared dead
//   cmd_t           : one queued command record (steps, speed)
package stepper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_START   = 3'd2,
    ST_RUN     = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  localparam int STEP_DIR_BIT    = 31;
  localparam int WATCHDOG_CYCLES = 8;
  localparam logic [3:0] WD_LAST = 4'(WATCHDOG_CYCLES - 1);

  typedef struct packed {
    logic [31:0] steps;
    logic [31:0] speed;
  } cmd_t;

  // A zero speed would stall the driver's half-period counter; run at the fastest rate instead.
  function automatic logic [31:0] clamp_speed(input logic [31:0] speed);
    logic [31:0] res;
    if (speed == 32'd0) begin
      res = 32'd1;
    end else begin
      res = speed;
    end
    return res;
  endfunction

endpackage

// File: rtl/stepper_cmd_fifo.sv
// Synchronous command FIFO, DEPTH x 64 bits, with occupancy output.
// Ports:
//   clk, reset_n       : clock, synchronous active-low reset
//   clear              : synchronous flush of all entries
//   wr_en, wr_data     : push (ignored when full)
//   rd_en, rd_data     : pop; rd_data shows the head entry combinationally
//   level, full, empty : occupancy status
module stepper_cmd_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [63:0]              wr_data,
  input  logic                     rd_en,
  output logic [63:0]              rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [63:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   level_r;
  logic          wr_ok_s;
  logic          rd_ok_s;

  assign full    = (level_r == (AW+1)'(DEPTH));
  assign empty   = (level_r == '0);
  assign wr_ok_s = wr_en && !full;
  assign rd_ok_s = rd_en && !empty;
  assign rd_data = mem_r[rd_ptr_r];
  assign level   = level_r;

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   level_r <= level_r + (AW+1)'(1'b1);
        2'b01:   level_r <= level_r - (AW+1)'(1'b1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

endmodule

// File: rtl/stepper_cmd_queue.sv
// Stepper command queue: buffers (steps, speed) commands and hands them to a
// stepper driver one at a time through a start_driving / stepper_driving handshake.
// Ports:
//   clk, reset_n                  : clock, synchronous active-low reset
//   cmd_steps, cmd_speed          : command write data (steps is sign-magnitude, bit31 = direction)
//   cmd_valid, cmd_ready          : command write handshake
//   flush                         : drop all queued commands and abort the active move
//   stepper_step_in, stepper_speed: active command held towards the driver
//   start_driving, stepper_driving: driver handshake
//   busy, level, done_pulse       : status
//   position                      : signed absolute step count
// Optional feature: define STEPPER_CMD_QUEUE_POSITION_EN to build the position
// accumulator; otherwise position is tied to zero.
module stepper_cmd_queue
  import stepper_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [31:0]            cmd_steps,
  input  logic [31:0]            cmd_speed,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   flush,
  output logic [31:0]            stepper_step_in,
  output logic [31:0]            stepper_speed,
  output logic                   start_driving,
  input  logic                   stepper_driving,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   done_pulse,
  output logic [31:0]            position
);

  state_t      state_r, state_nxt_s;
  logic [3:0]  wd_r, wd_nxt_s;
  logic        start_r, start_nxt_s;
  logic        done_r, done_nxt_s;
  logic [31:0] step_in_r;
  logic [31:0] speed_r;
  logic        pop_s;
  logic        fifo_wr_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic [63:0] fifo_rd_s;
  cmd_t        wr_cmd_s;

  assign wr_cmd_s  = '{steps: cmd_steps, speed: cmd_speed};
  assign cmd_ready = !fifo_full_s && !flush;
  assign fifo_wr_s = cmd_valid && cmd_ready;

  stepper_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (flush),
    .wr_en   (fifo_wr_s),
    .wr_data (wr_cmd_s),
    .rd_en   (pop_s),
    .rd_data (fifo_rd_s),
    .level   (level),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Next-state, pop and registered-output decode for the sequencer.
  always_comb begin
    state_nxt_s = state_r;
    wd_nxt_s    = wd_r;
    done_nxt_s  = 1'b0;
    pop_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!flush && !fifo_empty_s) begin
          pop_s       = 1'b1;
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (flush) begin
          state_nxt_s = ST_IDLE;
        end else if (step_in_r[30:0] == 31'd0) begin
          // Zero-length move: report it done without bothering the driver.
          done_nxt_s  = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          wd_nxt_s    = 4'd0;
          state_nxt_s = ST_START;
        end
      end
      ST_START: begin
        if (flush) begin
          state_nxt_s = ST_RELEASE;
        end else if (stepper_driving) begin
          state_nxt_s = ST_RUN;
        end else if (wd_r == WD_LAST) begin
          done_nxt_s  = 1'b1;
          state_nxt_s = ST_RELEASE;
        end else begin
          wd_nxt_s = wd_r + 4'd1;
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_nxt_s = ST_RELEASE;
        end else if (!stepper_driving) begin
          done_nxt_s  = 1'b1;
          state_nxt_s = ST_RELEASE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_RELEASE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    // start_driving is registered from the next state so it is glitch-free and
    // drops on the same edge that leaves RUN (including a flush-driven exit).
    start_nxt_s = (state_nxt_s == ST_START) || (state_nxt_s == ST_RUN);
  end

  // State, watchdog and output registers; command registers load only on a pop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      wd_r      <= 4'd0;
      start_r   <= 1'b0;
      done_r    <= 1'b0;
      step_in_r <= 32'd0;
      speed_r   <= 32'd1;
    end else begin
      state_r <= state_nxt_s;
      wd_r    <= wd_nxt_s;
      start_r <= start_nxt_s;
      done_r  <= done_nxt_s;
      if (pop_s) begin
        step_in_r <= fifo_rd_s[63:32];
        speed_r   <= clamp_speed(fifo_rd_s[31:0]);
      end
    end
  end

  assign stepper_step_in = step_in_r;
  assign stepper_speed   = speed_r;
  assign start_driving   = start_r;
  assign done_pulse      = done_r;
  assign busy            = (state_r != ST_IDLE) || !fifo_empty_s;

`ifdef STEPPER_CMD_QUEUE_POSITION_EN
  logic [31:0] position_r;
  logic        pos_upd_s;

  // Only a move the driver actually finished counts; flush and watchdog exits do not.
  assign pos_upd_s = (state_r == ST_RUN) && !flush && !stepper_driving;

  // Position accumulator, modulo 2^32.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      position_r <= 32'd0;
    end else if (pos_upd_s) begin
      if (step_in_r[STEP_DIR_BIT]) begin
        position_r <= position_r - {1'b0, step_in_r[30:0]};
      end else begin
        position_r <= position_r + {1'b0, step_in_r[30:0]};
      end
    end
  end

  assign position = position_r;
`else
  assign position = 32'd0;
`endif

endmodule
